sd_block_arbiter: RTL and testbench

- Shares the single HPS SD block-level channel (sd_lba/sd_rd/sd_wr/sd_ack/sd_buff_din) between NUM_REQ independent requesters.
- Requesters are the NVRAM backup channels, disk images and tape images.
- Round-robin arbitration, one block transaction per grant.
- The grant is locked from request until the host's ack falls; ack and buffer data are routed to and from the granted requester only.
- Sits between the requester blocks and hps_io.

---
 rtl/sd_block_arbiter.sv | 213 +++++++++++++++++++++
 tb/tb_sd_block_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_block_arbiter.sv
// Round-robin arbiter sharing the host SD block channel between NUM_REQ requesters.
// Optional ISSUE-phase ack timeout is enabled with `define SD_BLOCK_ARBITER_TIMEOUT_EN.
module sd_block_arbiter #(
   parameter int          NUM_REQ        = 4,
   parameter int          IDX_W          = 2,
   parameter logic [23:0] TIMEOUT_CYCLES = 24'hFFFFFF
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NUM_REQ-1:0]      req_rd,
   input  logic [NUM_REQ-1:0]      req_wr,
   input  logic [32*NUM_REQ-1:0]   req_lba,
   input  logic [8*NUM_REQ-1:0]    req_buff_din,
   output logic [NUM_REQ-1:0]      req_ack,
   output logic [31:0]             sd_lba,
   output logic                    sd_rd,
   output logic                    sd_wr,
   input  logic                    sd_ack,
   output logic [7:0]              sd_buff_din,
   output logic                    busy,
   output logic [IDX_W-1:0]        grant_id,
   output logic                    timeout_err
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_XFER  = 2'd2
   } state_t;

   localparam logic [IDX_W:0] NUM_REQ_W = (IDX_W+1)'(NUM_REQ);

   // Modulo-NUM_REQ add; NUM_REQ need not be a power of two.
   function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                 input logic [IDX_W:0]   off);
      logic [IDX_W:0] sum;
      sum = {1'b0, base} + off;
      if (sum >= NUM_REQ_W) begin
         sum = sum - NUM_REQ_W;
      end else begin
         sum = sum;
      end
      return sum[IDX_W-1:0];
   endfunction

   state_t           state_q;
   logic [IDX_W-1:0] rr_ptr_q;
   logic [IDX_W-1:0] grant_id_q;
   logic [31:0]      sd_lba_q;
   logic             sd_rd_q;
   logic             sd_wr_q;
   logic             busy_q;
   logic             last_ack_q;
   logic             timeout_err_q;
   logic [IDX_W-1:0] rr_ptr_d;
   logic             any_req_s;
   logic [IDX_W-1:0] win_idx_s;
   logic [IDX_W-1:0] cand_s;

   // Descending scan so the nearest requester at or after rr_ptr wins.
   always_comb begin
      any_req_s = 1'b0;
      win_idx_s = '0;
      cand_s    = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         cand_s = wrap_add(rr_ptr_q, (IDX_W+1)'(k));
         if (req_rd[cand_s] | req_wr[cand_s]) begin
            any_req_s = 1'b1;
            win_idx_s = cand_s;
         end else begin
            any_req_s = any_req_s;
         end
      end
   end

   assign rr_ptr_d = wrap_add(grant_id_q, (IDX_W+1)'(1));

   // Ack goes only to the holder of the grant.
   always_comb begin
      req_ack = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         req_ack[i] = sd_ack & busy_q & (grant_id_q == IDX_W'(i));
      end
   end

   assign sd_buff_din = busy_q ? req_buff_din[8*grant_id_q +: 8] : 8'h00;

`ifdef SD_BLOCK_ARBITER_TIMEOUT_EN
   logic [23:0] to_cnt_q;

   // Grant FSM with ISSUE-phase abort when the host never acks.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         rr_ptr_q      <= '0;
         grant_id_q    <= '0;
         sd_lba_q      <= 32'h0;
         sd_rd_q       <= 1'b0;
         sd_wr_q       <= 1'b0;
         busy_q        <= 1'b0;
         last_ack_q    <= 1'b0;
         timeout_err_q <= 1'b0;
         to_cnt_q      <= 24'h0;
      end else begin
         last_ack_q    <= sd_ack;
         timeout_err_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (any_req_s) begin
                  grant_id_q <= win_idx_s;
                  sd_lba_q   <= req_lba[32*win_idx_s +: 32];
                  sd_wr_q    <= req_wr[win_idx_s];
                  sd_rd_q    <= req_rd[win_idx_s] & ~req_wr[win_idx_s];
                  busy_q     <= 1'b1;
                  to_cnt_q   <= 24'h0;
                  state_q    <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (sd_ack) begin
                  sd_rd_q <= 1'b0;
                  sd_wr_q <= 1'b0;
                  state_q <= ST_XFER;
               end else if (to_cnt_q == TIMEOUT_CYCLES - 24'd1) begin
                  sd_rd_q       <= 1'b0;
                  sd_wr_q       <= 1'b0;
                  timeout_err_q <= 1'b1;
                  busy_q        <= 1'b0;
                  rr_ptr_q      <= rr_ptr_d;
                  state_q       <= ST_IDLE;
               end else begin
                  to_cnt_q <= to_cnt_q + 24'd1;
               end
            end
            ST_XFER: begin
               if (last_ack_q && !sd_ack) begin
                  rr_ptr_q <= rr_ptr_d;
                  busy_q   <= 1'b0;
                  state_q  <= ST_IDLE;
               end
            end
            default: begin
               sd_rd_q <= 1'b0;
               sd_wr_q <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end
`else
   logic timeout_unused_s;
   assign timeout_unused_s = ^TIMEOUT_CYCLES;

   // Grant FSM; ISSUE waits for the host ack indefinitely.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         rr_ptr_q      <= '0;
         grant_id_q    <= '0;
         sd_lba_q      <= 32'h0;
         sd_rd_q       <= 1'b0;
         sd_wr_q       <= 1'b0;
         busy_q        <= 1'b0;
         last_ack_q    <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         last_ack_q    <= sd_ack;
         timeout_err_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (any_req_s) begin
                  grant_id_q <= win_idx_s;
                  sd_lba_q   <= req_lba[32*win_idx_s +: 32];
                  sd_wr_q    <= req_wr[win_idx_s];
                  sd_rd_q    <= req_rd[win_idx_s] & ~req_wr[win_idx_s];
                  busy_q     <= 1'b1;
                  state_q    <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (sd_ack) begin
                  sd_rd_q <= 1'b0;
                  sd_wr_q <= 1'b0;
                  state_q <= ST_XFER;
               end
            end
            ST_XFER: begin
               if (last_ack_q && !sd_ack) begin
                  rr_ptr_q <= rr_ptr_d;
                  busy_q   <= 1'b0;
                  state_q  <= ST_IDLE;
               end
            end
            default: begin
               sd_rd_q <= 1'b0;
               sd_wr_q <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end
`endif

   assign sd_lba      = sd_lba_q;
   assign sd_rd       = sd_rd_q;
   assign sd_wr       = sd_wr_q;
   assign busy        = busy_q;
   assign grant_id    = grant_id_q;
   assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_sd_block_arbiter.sv
// Scoreboard bench for sd_block_arbiter: expected grants are queued as requests are driven
// and checked when the arbiter strobes the host.
module tb_sd_block_arbiter;

   localparam int NUM_REQ = 4;
   localparam int IDX_W   = 2;
`ifdef SD_BLOCK_ARBITER_TIMEOUT_EN
   localparam logic [23:0] TO_CYC = 24'd100;
`else
   localparam logic [23:0] TO_CYC = 24'hFFFFFF;
`endif

   typedef struct packed {
      logic [2:0]  id;
      logic [31:0] lba;
      logic        wr;
      logic [7:0]  data;
   } exp_t;

   logic                  clk = 1'b0;
   logic                  reset;
   logic [NUM_REQ-1:0]    req_rd;
   logic [NUM_REQ-1:0]    req_wr;
   logic [32*NUM_REQ-1:0] req_lba;
   logic [8*NUM_REQ-1:0]  req_buff_din;
   logic [NUM_REQ-1:0]    req_ack;
   logic [31:0]           sd_lba;
   logic                  sd_rd;
   logic                  sd_wr;
   logic                  sd_ack;
   logic [7:0]            sd_buff_din;
   logic                  busy;
   logic [IDX_W-1:0]      grant_id;
   logic                  timeout_err;

   int   n_tests = 0;
   int   n_fail  = 0;
   exp_t exp_q[$];

   sd_block_arbiter #(
      .NUM_REQ(NUM_REQ), .IDX_W(IDX_W), .TIMEOUT_CYCLES(TO_CYC)
   ) dut (
      .clk(clk), .reset(reset), .req_rd(req_rd), .req_wr(req_wr), .req_lba(req_lba),
      .req_buff_din(req_buff_din), .req_ack(req_ack), .sd_lba(sd_lba), .sd_rd(sd_rd),
      .sd_wr(sd_wr), .sd_ack(sd_ack), .sd_buff_din(sd_buff_din), .busy(busy),
      .grant_id(grant_id), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int i, input logic rd, input logic wr,
                          input logic [31:0] lba, input logic [7:0] data);
      req_rd[i]               = rd;
      req_wr[i]               = wr;
      req_lba[32*i +: 32]     = lba;
      req_buff_din[8*i +: 8]  = data;
   endtask

   task automatic push(input int id, input logic [31:0] lba, input logic wr, input logic [7:0] data);
      exp_t e;
      e.id   = 3'(id);
      e.lba  = lba;
      e.wr   = wr;
      e.data = data;
      exp_q.push_back(e);
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      sd_ack = 1'b0;
      req_rd = '0;
      req_wr = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   // Host model: wait for a strobe, check it against the queue, ack for ack_len cycles.
   task automatic serve(input int ack_len, input bit keep_rd, output int waited);
      exp_t e;
      int   bad_ack;
      int   bad_din;
      bit   seen;
      seen    = 1'b0;
      waited  = 0;
      bad_ack = 0;
      bad_din = 0;
      while (!seen && waited < 64) begin
         @(negedge clk);
         waited++;
         if (sd_rd | sd_wr) seen = 1'b1;
      end
      chk("strobe_seen", 32'(seen), 32'd1);
      if (!seen) return;
      if (exp_q.size() == 0) begin
         chk("queue_nonempty", 32'd0, 32'd1);
         return;
      end
      e = exp_q.pop_front();
      chk("grant_id", 32'(grant_id), 32'(e.id));
      chk("sd_lba", sd_lba, e.lba);
      chk("sd_wr", 32'(sd_wr), 32'(e.wr));
      chk("sd_rd", 32'(sd_rd), 32'(!e.wr));
      chk("busy_on", 32'(busy), 32'd1);
      sd_ack = 1'b1;
      for (int c = 0; c < ack_len; c++) begin
         @(negedge clk);
         if (c == 0) begin
            chk("strobe_clr", 32'({sd_rd, sd_wr}), 32'd0);
            req_wr[e.id] = 1'b0;
            if (!keep_rd) req_rd[e.id] = 1'b0;
         end
         if (req_ack !== (4'b0001 << e.id)) bad_ack++;
         if (sd_buff_din !== e.data) bad_din++;
      end
      chk("req_ack_mirror_errs", 32'(bad_ack), 32'd0);
      chk("buff_din_errs", 32'(bad_din), 32'd0);
      sd_ack = 1'b0;
      @(negedge clk);
      chk("busy_rel", 32'(busy), 32'd0);
      chk("req_ack_rel", 32'(req_ack), 32'd0);
      chk("din_rel", 32'(sd_buff_din), 32'd0);
      chk("gid_hold", 32'(grant_id), 32'(e.id));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      req_lba      = '0;
      req_buff_din = '0;
      apply_reset();
      reset = 1'b1;
      #1;
      chk("rst_sd_rd", 32'(sd_rd), 32'd0);
      chk("rst_sd_wr", 32'(sd_wr), 32'd0);
      chk("rst_sd_lba", sd_lba, 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_gid", 32'(grant_id), 32'd0);
      chk("rst_to_err", 32'(timeout_err), 32'd0);
      chk("rst_req_ack", 32'(req_ack), 32'd0);
      chk("rst_din", 32'(sd_buff_din), 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // Spurious ack while idle
      sd_ack = 1'b1;
      @(negedge clk);
      chk("spur_req_ack", 32'(req_ack), 32'd0);
      chk("spur_busy", 32'(busy), 32'd0);
      sd_ack = 1'b0;
      @(negedge clk);

      // Single read from requester 2 with a 512-cycle ack
      set_req(2, 1'b1, 1'b0, 32'h0000_0010, 8'h5A);
      push(2, 32'h0000_0010, 1'b0, 8'h5A);
      serve(512, 1'b0, w);
      chk("rd_latency", 32'(w), 32'd1);

      // Four simultaneous writes from reset, then 0 re-asserted after 1 completes
      apply_reset();
      for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b0, 1'b1, 32'h100 + 32'(i), 8'h10 + 8'(i));
      push(0, 32'h100, 1'b1, 8'h10);
      push(1, 32'h101, 1'b1, 8'h11);
      serve(4, 1'b0, w);
      serve(4, 1'b0, w);
      set_req(0, 1'b0, 1'b1, 32'h100, 8'h10);
      push(2, 32'h102, 1'b1, 8'h12);
      push(3, 32'h103, 1'b1, 8'h13);
      push(0, 32'h100, 1'b1, 8'h10);
      for (int n = 0; n < 3; n++) serve(3, 1'b0, w);

      // Read and write together: write wins, then the held read follows
      set_req(1, 1'b1, 1'b1, 32'd5, 8'h00);
      push(1, 32'd5, 1'b1, 8'h00);
      serve(3, 1'b1, w);
      push(1, 32'd5, 1'b0, 8'h00);
      serve(3, 1'b0, w);

      // Write data mux for requester 3
      req_buff_din = '0;
      set_req(3, 1'b0, 1'b1, 32'h33, 8'hA5);
      push(3, 32'h33, 1'b1, 8'hA5);
      serve(8, 1'b0, w);

      // Reset in the middle of a transfer; pending requests restart from pointer 0
      set_req(2, 1'b1, 1'b0, 32'h77, 8'h22);
      @(negedge clk);
      chk("mid_sd_rd", 32'(sd_rd), 32'd1);
      sd_ack = 1'b1;
      @(negedge clk);
      chk("mid_req_ack", 32'(req_ack), 32'h4);
      set_req(3, 1'b0, 1'b1, 32'h300, 8'h03);
      set_req(0, 1'b0, 1'b1, 32'h400, 8'h04);
      reset = 1'b1;
      #1;
      chk("mid_rst_rd", 32'(sd_rd), 32'd0);
      chk("mid_rst_wr", 32'(sd_wr), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_ack", 32'(req_ack), 32'd0);
      @(negedge clk);
      sd_ack = 1'b0;
      reset  = 1'b0;
      push(0, 32'h400, 1'b1, 8'h04);
      push(2, 32'h77, 1'b0, 8'h22);
      push(3, 32'h300, 1'b1, 8'h03);
      for (int n = 0; n < 3; n++) serve(3, 1'b0, w);

`ifdef SD_BLOCK_ARBITER_TIMEOUT_EN
      begin
         int  cyc;
         bit  hit;
         set_req(0, 1'b1, 1'b0, 32'h500, 8'h50);
         set_req(1, 1'b1, 1'b0, 32'h501, 8'h51);
         @(negedge clk);
         chk("to_strobe", 32'(sd_rd), 32'd1);
         chk("to_gid", 32'(grant_id), 32'd0);
         cyc = 0;
         hit = 1'b0;
         while (!hit && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (timeout_err) hit = 1'b1;
         end
         chk("to_cycle", 32'(cyc), 32'd100);
         chk("to_busy", 32'(busy), 32'd0);
         @(negedge clk);
         chk("to_pulse_once", 32'(timeout_err), 32'd0);
         push(1, 32'h501, 1'b0, 8'h51);
         push(0, 32'h500, 1'b0, 8'h50);
         serve(3, 1'b0, w);
         serve(3, 1'b0, w);
      end
`endif

      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
